// File: rtl/knn_pkg.sv
// knn_pkg
// Shared definitions for the k-NN pipeline: default datapath widths (common
// with the distance engine), the top-k/vote FSM state encoding and a
// saturating counter helper.
package knn_pkg;

    localparam int KNN_DATA_WIDTH  = 32;
    localparam int KNN_CLASS_WIDTH = 8;
    localparam int KNN_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_VOTE    = 2'd1,
        ST_OUTPUT  = 2'd2
    } knn_state_t;

    // Pair counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [KNN_COUNT_WIDTH-1:0] sat_inc(input logic [KNN_COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + KNN_COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/knn_topk_vote_if.sv
// knn_topk_vote_if
// Bundles the two handshake streams of the top-k vote stage.
//   in_*  : (distance, class, last) pairs from the distance engine, valid/ready
//   out_* : one classification result per query, valid/ready
// Modports:
//   master : the environment side (drives pairs, consumes results)
//   slave  : the knn_topk_vote side
interface knn_topk_vote_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int CLASS_WIDTH = 8,
    parameter int VOTE_WIDTH  = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_distance;
    logic [CLASS_WIDTH-1:0] in_class;
    logic                   in_last;

    logic                   out_valid;
    logic                   out_ready;
    logic [CLASS_WIDTH-1:0] out_class;
    logic [VOTE_WIDTH-1:0]  out_votes;
    logic [DATA_WIDTH-1:0]  out_min_distance;
    logic [15:0]            out_count;

    modport master (
        output in_valid, in_distance, in_class, in_last, out_ready,
        input  in_ready, out_valid, out_class, out_votes, out_min_distance, out_count
    );

    modport slave (
        input  in_valid, in_distance, in_class, in_last, out_ready,
        output in_ready, out_valid, out_class, out_votes, out_min_distance, out_count
    );
endinterface

// File: rtl/knn_sorted_slot.sv
// knn_sorted_slot
// One cell of the sorted nearest-neighbour register file.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   clear                        invalidate the slot (end of query)
//   insert                       an incoming pair is being inserted somewhere
//   prev_le                      compare flag of the slot above (1 for slot 0)
//   prev_distance/class/valid    contents of the slot above (shift source)
//   new_distance/class           the incoming pair
//   le                           this slot is valid and distance <= new_distance
//   distance, label, valid       slot contents
module knn_sorted_slot
    import knn_pkg::*;
#(
    parameter int DATA_WIDTH  = KNN_DATA_WIDTH,
    parameter int CLASS_WIDTH = KNN_CLASS_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   insert,
    input  logic                   prev_le,
    input  logic [DATA_WIDTH-1:0]  prev_distance,
    input  logic [CLASS_WIDTH-1:0] prev_class,
    input  logic                   prev_valid,
    input  logic [DATA_WIDTH-1:0]  new_distance,
    input  logic [CLASS_WIDTH-1:0] new_class,
    output logic                   le,
    output logic [DATA_WIDTH-1:0]  distance,
    output logic [CLASS_WIDTH-1:0] label,
    output logic                   valid
);

    // An empty slot never reports <=, so it always sorts after real data.
    assign le = valid && (distance <= new_distance);

    // Flags are monotonic down the chain (1..1 0..0). The first slot with
    // le=0 takes the new pair; every slot below it takes its upper
    // neighbour; slots with le=1 keep their contents, which keeps equal
    // distances in arrival order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid    <= 1'b0;
            distance <= '0;
            label    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (insert && !le) begin
            if (prev_le) begin
                valid    <= 1'b1;
                distance <= new_distance;
                label    <= new_class;
            end else begin
                valid    <= prev_valid;
                distance <= prev_distance;
                label    <= prev_class;
            end
        end
    end

endmodule

// File: rtl/knn_topk_vote.sv
// knn_topk_vote
// Keeps the K nearest (distance, class) pairs of a query in a sorted slot
// chain and, after the last pair, emits the majority class among them.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-low reset
//   bus  knn_topk_vote_if.slave: input pair stream and result stream
module knn_topk_vote
    import knn_pkg::*;
#(
    parameter int K           = 3,
    parameter int DATA_WIDTH  = KNN_DATA_WIDTH,
    parameter int CLASS_WIDTH = KNN_CLASS_WIDTH,
    parameter int VOTE_WIDTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    knn_topk_vote_if.slave     bus
);

    knn_state_t state;
    logic       in_ready_q;
    logic [KNN_COUNT_WIDTH-1:0] count;

    logic                   out_valid_q;
    logic [CLASS_WIDTH-1:0] out_class_q;
    logic [VOTE_WIDTH-1:0]  out_votes_q;
    logic [DATA_WIDTH-1:0]  out_min_q;
    logic [KNN_COUNT_WIDTH-1:0] out_count_q;

    logic [DATA_WIDTH-1:0]  slot_distance [K];
    logic [CLASS_WIDTH-1:0] slot_class    [K];
    logic [K-1:0]           slot_valid;
    logic [K-1:0]           slot_le;

    logic beat;
    logic insert;
    logic clear;

    // in_ready_q is only ever high in COLLECT, so it doubles as the state qualifier.
    assign beat   = bus.in_valid && in_ready_q;
    // When even the last slot is <= the new distance the pair lands at
    // position K and is dropped.
    assign insert = beat && !slot_le[K-1];
    assign clear  = (state == ST_OUTPUT) && bus.out_ready;

    for (genvar i = 0; i < K; i++) begin : g_slot
        logic                   prev_le;
        logic [DATA_WIDTH-1:0]  prev_distance;
        logic [CLASS_WIDTH-1:0] prev_class;
        logic                   prev_valid;

        if (i == 0) begin : g_head
            assign prev_le       = 1'b1;
            assign prev_distance = bus.in_distance;
            assign prev_class    = bus.in_class;
            assign prev_valid    = 1'b0;
        end else begin : g_tail
            assign prev_le       = slot_le[i-1];
            assign prev_distance = slot_distance[i-1];
            assign prev_class    = slot_class[i-1];
            assign prev_valid    = slot_valid[i-1];
        end

        knn_sorted_slot #(
            .DATA_WIDTH  (DATA_WIDTH),
            .CLASS_WIDTH (CLASS_WIDTH)
        ) u_slot (
            .clk           (clk),
            .rst           (rst),
            .clear         (clear),
            .insert        (insert),
            .prev_le       (prev_le),
            .prev_distance (prev_distance),
            .prev_class    (prev_class),
            .prev_valid    (prev_valid),
            .new_distance  (bus.in_distance),
            .new_class     (bus.in_class),
            .le            (slot_le[i]),
            .distance      (slot_distance[i]),
            .label         (slot_class[i]),
            .valid         (slot_valid[i])
        );
    end

    // Majority vote over valid slots. Scanning from slot 0 with a strict '>'
    // means a tie goes to the class whose nearest member is closest.
    logic [CLASS_WIDTH-1:0] win_class;
    logic [VOTE_WIDTH-1:0]  win_votes;

    always_comb begin
        win_class = '0;
        win_votes = '0;
        for (int i = 0; i < K; i++) begin
            logic [VOTE_WIDTH-1:0] votes;
            votes = '0;
            for (int j = 0; j < K; j++) begin
                if (slot_valid[i] && slot_valid[j] && (slot_class[j] == slot_class[i])) begin
                    votes = votes + VOTE_WIDTH'(1);
                end
            end
            if (slot_valid[i] && (votes > win_votes)) begin
                win_votes = votes;
                win_class = slot_class[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_COLLECT;
            in_ready_q  <= 1'b0;
            count       <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_votes_q <= '0;
            out_min_q   <= '0;
            out_count_q <= '0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    in_ready_q <= 1'b1;
                    if (beat) begin
                        count <= sat_inc(count);
                        if (bus.in_last) begin
                            state      <= ST_VOTE;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                ST_VOTE: begin
                    out_class_q <= win_class;
                    out_votes_q <= win_votes;
                    out_min_q   <= slot_distance[0];
                    out_count_q <= count;
                    out_valid_q <= 1'b1;
                    state       <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        count       <= '0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_COLLECT;
                    end
                end
                default: begin
                    state      <= ST_COLLECT;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_class        = out_class_q;
    assign bus.out_votes        = out_votes_q;
    assign bus.out_min_distance = out_min_q;
    assign bus.out_count        = out_count_q;

endmodule

// File: tb/tb_knn_topk_vote.sv
// tb_knn_topk_vote
// Drives pair streams into knn_topk_vote and compares every result against a
// reference that picks the K nearest pairs by repeated minimum search over the
// whole query and votes over them.
module tb_knn_topk_vote;

    localparam int K  = 3;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int VW = 4;

    logic clk;
    logic rst;

    knn_topk_vote_if #(.DATA_WIDTH(DW), .CLASS_WIDTH(CW), .VOTE_WIDTH(VW)) bus ();

    knn_topk_vote #(
        .K           (K),
        .DATA_WIDTH  (DW),
        .CLASS_WIDTH (CW),
        .VOTE_WIDTH  (VW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Stimulus for the current query and the reference result for it.
    logic [DW-1:0] stim_d [256];
    logic [CW-1:0] stim_c [256];
    logic [CW-1:0] m_cls;
    int            m_votes;
    logic [DW-1:0] m_min;
    int            m_count;

    // Expected results in order, with the cycle index their valid must appear.
    logic [CW-1:0] exp_cls   [$];
    int            exp_votes [$];
    logic [DW-1:0] exp_min   [$];
    int            exp_count [$];
    int            exp_due   [$];

    int ready_mode = 1;
    bit gap_en     = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_abort(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired at cycle %0d", name, cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Stable selection of the K smallest distances, then a vote where the
    // earliest selected entry wins among equal counts.
    function automatic void model_eval(input int n);
        bit used [256];
        int top  [K];
        int ntop;
        ntop = (n < K) ? n : K;
        for (int j = 0; j < n; j++) used[j] = 1'b0;
        for (int k = 0; k < ntop; k++) begin
            int best;
            best = -1;
            for (int j = 0; j < n; j++) begin
                if (!used[j] && (best < 0 || stim_d[j] < stim_d[best])) best = j;
            end
            used[best] = 1'b1;
            top[k] = best;
        end
        m_votes = 0;
        m_cls   = '0;
        for (int a = 0; a < ntop; a++) begin
            int cnt;
            cnt = 0;
            for (int b = 0; b < ntop; b++) begin
                if (stim_c[top[b]] == stim_c[top[a]]) cnt++;
            end
            if (cnt > m_votes) begin
                m_votes = cnt;
                m_cls   = stim_c[top[a]];
            end
        end
        m_min   = stim_d[top[0]];
        m_count = (n > 65535) ? 65535 : n;
    endfunction

    // Sends stim[0..n-1]; with_last=0 leaves the query open.
    task automatic applyStimulus(input int n, input bit with_last);
        bit rdy;
        int waited;
        model_eval(n);
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            if (gap_en) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_valid    = 1'b1;
            bus.in_distance = stim_d[i];
            bus.in_class    = stim_c[i];
            bus.in_last     = with_last && (i == n - 1);
            waited = 0;
            rdy    = 1'b0;
            while (!rdy) begin
                @(negedge clk);
                rdy = bus.in_ready;
                @(posedge clk);
                #1;
                if (!rdy) begin
                    waited++;
                    if (waited > 3000) fail_abort("in_ready_timeout");
                end
            end
            if (with_last && (i == n - 1)) begin
                exp_cls.push_back(m_cls);
                exp_votes.push_back(m_votes);
                exp_min.push_back(m_min);
                exp_count.push_back(m_count);
                exp_due.push_back(cyc + 1);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        @(negedge clk);
        while (exp_cls.size() != 0 || bus.out_valid) begin
            @(negedge clk);
            waited++;
            if (waited > 3000) fail_abort("result_timeout");
        end
    endtask

    task automatic wait_valid();
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.out_valid) begin
            @(negedge clk);
            waited++;
            if (waited > 3000) fail_abort("valid_timeout");
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_out_valid"}, bus.out_valid, 0);
        checkOutput({tag, "_out_class"}, bus.out_class, 0);
        checkOutput({tag, "_out_votes"}, bus.out_votes, 0);
        checkOutput({tag, "_out_min"},   bus.out_min_distance, 0);
        checkOutput({tag, "_out_count"}, bus.out_count, 0);
        checkOutput({tag, "_in_ready"},  bus.in_ready, 0);
    endtask

    task automatic set_stim(input int i, input logic [DW-1:0] d, input logic [CW-1:0] c);
        stim_d[i] = d;
        stim_c[i] = c;
    endtask

    task automatic pin_model(input string tag, input int cls, input int votes, input int mind, input int count);
        checkOutput({tag, "_model_class"}, m_cls, cls);
        checkOutput({tag, "_model_votes"}, m_votes, votes);
        checkOutput({tag, "_model_min"},   m_min, mind);
        checkOutput({tag, "_model_count"}, m_count, count);
    endtask

    // out_ready is owned by this process only.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Result monitor: new results against the reference queue, held results
    // for stability, and in_ready low whenever a result is pending.
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [CW-1:0] hold_cls;
    logic [VW-1:0] hold_votes;
    logic [DW-1:0] hold_min;
    logic [15:0]   hold_count;

    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) checkOutput("valid_held", bus.out_valid, 1);
            if (prev_valid && prev_ready)  checkOutput("valid_clears", bus.out_valid, 0);
            if (bus.out_valid) begin
                checkOutput("in_ready_low_while_result", bus.in_ready, 0);
                if (!prev_valid) begin
                    if (exp_cls.size() == 0) begin
                        checkOutput("unexpected_result", bus.out_valid, 0);
                    end else begin
                        checkOutput("out_class", bus.out_class, exp_cls.pop_front());
                        checkOutput("out_votes", bus.out_votes, exp_votes.pop_front());
                        checkOutput("out_min_distance", bus.out_min_distance, exp_min.pop_front());
                        checkOutput("out_count", bus.out_count, exp_count.pop_front());
                        checkOutput("latency_cycle", cyc, exp_due.pop_front());
                    end
                    hold_cls   = bus.out_class;
                    hold_votes = bus.out_votes;
                    hold_min   = bus.out_min_distance;
                    hold_count = bus.out_count;
                end else if (!prev_ready) begin
                    checkOutput("hold_class", bus.out_class, hold_cls);
                    checkOutput("hold_votes", bus.out_votes, hold_votes);
                    checkOutput("hold_min",   bus.out_min_distance, hold_min);
                    checkOutput("hold_count", bus.out_count, hold_count);
                end
            end
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
        end
    end

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_distance = '0;
        bus.in_class    = '0;
        bus.in_last     = 1'b0;
        bus.out_ready   = 1'b1;

        // Reset state and registered in_ready release.
        #1 rst = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_before_first_clk", bus.in_ready, 0);
        @(posedge clk);
        #1 checkOutput("in_ready_after_first_clk", bus.in_ready, 1);

        ready_mode = 1;
        gap_en     = 0;

        $display("[TB] basic query");
        set_stim(0, 5100, 0); set_stim(1, 4900, 0); set_stim(2, 7000, 1);
        set_stim(3, 100, 1);  set_stim(4, 6400, 1);
        model_eval(5);
        pin_model("basic", 0, 2, 100, 5);
        applyStimulus(5, 1);
        wait_idle();

        $display("[TB] equal distances");
        set_stim(0, 300, 1); set_stim(1, 300, 2); set_stim(2, 300, 1); set_stim(3, 300, 2);
        model_eval(4);
        pin_model("tie", 1, 2, 300, 4);
        applyStimulus(4, 1);
        wait_idle();

        $display("[TB] single point");
        set_stim(0, 42, 7);
        model_eval(1);
        pin_model("single", 7, 1, 42, 1);
        applyStimulus(1, 1);
        wait_idle();

        $display("[TB] all-distinct vote");
        set_stim(0, 10, 3); set_stim(1, 20, 4); set_stim(2, 30, 5);
        model_eval(3);
        pin_model("alltie", 3, 1, 10, 3);
        applyStimulus(3, 1);
        wait_idle();

        $display("[TB] backpressure");
        ready_mode = 0;
        set_stim(0, 900, 9); set_stim(1, 800, 8); set_stim(2, 700, 8); set_stim(3, 600, 9);
        applyStimulus(4, 1);
        wait_valid();
        set_stim(0, 11, 2); set_stim(1, 12, 2);
        fork
            applyStimulus(2, 1);
            begin
                repeat (10) @(posedge clk);
                #1 ready_mode = 1;
            end
        join
        wait_idle();

        $display("[TB] reset mid-query");
        set_stim(0, 1, 9); set_stim(1, 2, 9); set_stim(2, 3, 9);
        applyStimulus(3, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check_all_zero("midquery_reset");
        @(posedge clk);
        #1 rst = 1'b1;
        set_stim(0, 50, 5); set_stim(1, 60, 6);
        model_eval(2);
        pin_model("after_reset", 5, 1, 50, 2);
        applyStimulus(2, 1);
        wait_idle();

        $display("[TB] reset while result held");
        ready_mode = 0;
        set_stim(0, 70, 1); set_stim(1, 71, 1);
        applyStimulus(2, 1);
        wait_valid();
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check_all_zero("output_reset");
        ready_mode = 1;
        @(posedge clk);
        #1 rst = 1'b1;

        $display("[TB] random queries");
        ready_mode = 2;
        gap_en     = 1;
        for (int q = 0; q < 40; q++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1) stim_d[i] = DW'($urandom_range(0, 15));
                else                           stim_d[i] = $urandom();
                stim_c[i] = CW'($urandom_range(0, 3));
            end
            applyStimulus(n, 1);
        end
        ready_mode = 1;
        wait_idle();
        checkOutput("results_drained", exp_cls.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/knn_topk_vote.md
Name: knn_topk_vote

Overview:
- Downstream stage of the k-NN distance engine.
- Consumes one stream of (distance, class) pairs per query, one pair per training point. Keeps the K smallest distances in a sorted register file, then takes a majority vote over their class labels.
- Emits one classification result per query on a valid/ready output. The result can be packed onto the PS-bound AXIS master.

Parameters:
- K, 3: number of nearest neighbours kept and voted (1..8).
- DATA_WIDTH, 32: distance width, unsigned.
- CLASS_WIDTH, 8: class label width.
- VOTE_WIDTH, 4: vote counter width; must satisfy 2^VOTE_WIDTH > K.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  pair valid.
- in_ready  out  1  block can accept a pair.
- in_distance  in  DATA_WIDTH  distance of current training point.
- in_class  in  CLASS_WIDTH  label of current training point.
- in_last  in  1  final training point of this query.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_class  out  CLASS_WIDTH  winning class.
- out_votes  out  VOTE_WIDTH  number of the K slots holding the winning class.
- out_min_distance  out  DATA_WIDTH  smallest distance seen in the query.
- out_count  out  16  pairs accepted for the query (saturates at 16'hFFFF).

Behaviour:
- Reset (rst low, asynchronous):
  - state COLLECT; all slot valid bits 0; count 0.
  - out_valid 0, out_class 0, out_votes 0, out_min_distance 0, out_count 0.
  - in_ready becomes 1 on the first clk after rst deasserts (registered).
- Reset asserted mid-query discards the partial query with no output.
- FSM COLLECT:
  - in_ready=1.
  - Beat accepted when in_valid & in_ready.
  - Accepted pair is inserted into the sorted slots 0..K-1, ascending distance, slot 0 nearest.
  - Insertion position = number of valid slots whose distance <= in_distance. Equal distances keep arrival order (stable).
  - Slots at and after the insertion position shift down by one; slot K-1 drops out.
  - If the position is K, the pair is discarded.
  - Empty (invalid) slots compare as larger than any distance.
  - count increments per beat.
  - Beat with in_last moves to VOTE next cycle.
- FSM VOTE (exactly 1 cycle, in_ready=0):
  - For each valid slot i, votes_i = number of valid slots with class equal to slot i's class.
  - Winner = slot with max votes_i. Ties go to the lowest slot index, i.e. the class whose nearest member is closer.
  - Register out_class, out_votes, out_min_distance=slot0 distance, out_count. Set out_valid=1. Go to OUTPUT.
- FSM OUTPUT (in_ready=0):
  - Hold all outputs stable while out_valid & !out_ready.
  - On out_ready: next cycle out_valid=0, all slots invalidated, count cleared, go to COLLECT.
- Latency: result valid 2 cycles after the in_last beat is accepted (1 cycle transition + VOTE).
- Throughput: 1 pair/cycle in COLLECT. Next query stalls until the result is consumed; no overlap.
- Boundary conditions:
  - Query with fewer than K points votes only over valid slots.
  - Single-point query: out_votes=1, class = that point's class.
  - in_valid while in_ready=0 is ignored and must be held by upstream (AXIS rules).
  - Distance arithmetic is unsigned compare only; no overflow possible.

Decomposition:
- Shared package knn_pkg holds:
  - DATA_WIDTH / CLASS_WIDTH defaults, shared with the distance engine.
  - State encoding constants ST_COLLECT=2'd0, ST_VOTE=2'd1, ST_OUTPUT=2'd2.
- One natural sub-module: knn_sorted_slot. It is one slot cell holding distance, class and valid. It takes its neighbour's contents and the shift/insert enable, and produces the "<= in_distance" compare flag.
- Top level chains K knn_sorted_slot instances and holds the FSM and voter.

Test Plan:
- K=3, stream (5100,0)(4900,0)(7000,1)(100,1)(6400,1), last on 5th, out_ready=1 -> slots {100:1, 4900:0, 5100:0}; out_class=0, out_votes=2, out_min_distance=100, out_count=5; out_valid 2 cycles after last.
- Tie: stream (300,1)(300,2)(300,1)(300,2) -> slots {1,2,1}; out_class=1, out_votes=2. Proves stable insertion and tie rule.
- Short query: single beat (42,7) with last -> out_class=7, out_votes=1, out_min_distance=42, out_count=1.
- Backpressure: out_ready=0 for 10 cycles after result -> outputs stable, in_ready=0, new in_valid beats not accepted. After out_ready=1, next query results are independent of the previous query.
- All-tie vote: stream (10,3)(20,4)(30,5) -> out_class=3 (lowest slot), out_votes=1.
- Async reset: assert rst low mid-query between clock edges -> out_valid=0 and outputs 0 immediately. A subsequent full query gives correct results with no leftover slot contents.
